// File: rtl/fmul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fmul_pipe
// Purpose  : Pipelined IEEE-754-style multiplier with RNE rounding,
//            flush-to-zero, NaN propagation, sideband tag and exception flags.
// Revision : 1.0 - initial release
// ============================================================================
module fmul_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              a_sign,
    input  logic [EXP_W-1:0]  a_exp,
    input  logic [FRAC_W-1:0] a_frac,
    input  logic              b_sign,
    input  logic [EXP_W-1:0]  b_exp,
    input  logic [FRAC_W-1:0] b_frac,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign,
    output logic [EXP_W-1:0]  exp,
    output logic [FRAC_W-1:0] frac,
    output logic [TAG_W-1:0]  out_tag,
    output logic              invalid,
    output logic              overflow,
    output logic              underflow,
    output logic              inexact
);

    localparam int c_MANT_W = FRAC_W + 1;
    localparam int c_PROD_W = 2 * c_MANT_W;
    localparam int c_SE_W   = EXP_W + 2;

    localparam logic [c_SE_W-1:0] c_BIAS    = c_SE_W'((1 << (EXP_W - 1)) - 1);
    localparam logic [c_SE_W-1:0] c_EXP_MAX = c_SE_W'((1 << EXP_W) - 1);
    localparam logic [FRAC_W-1:0] c_QNAN_FRAC = {1'b1, {(FRAC_W-1){1'b0}}};

    localparam logic [1:0] c_SPC_NONE = 2'd0;
    localparam logic [1:0] c_SPC_NAN  = 2'd1;
    localparam logic [1:0] c_SPC_INF  = 2'd2;
    localparam logic [1:0] c_SPC_ZERO = 2'd3;

    // Whole pipe moves in lockstep; a stalled output freezes every stage.
    logic w_adv;
    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;

    // ------------------------------------------------------------------
    // S1: operand capture and classification
    // ------------------------------------------------------------------
    logic w_a_max, w_b_max;
    logic w_a_zero, w_a_inf, w_a_nan;
    logic w_b_zero, w_b_inf, w_b_nan;

    assign w_a_max  = &a_exp;
    assign w_b_max  = &b_exp;
    assign w_a_zero = (a_exp == '0);
    assign w_b_zero = (b_exp == '0);
    assign w_a_inf  = w_a_max & (a_frac == '0);
    assign w_b_inf  = w_b_max & (b_frac == '0);
    assign w_a_nan  = w_a_max & (a_frac != '0);
    assign w_b_nan  = w_b_max & (b_frac != '0);

    logic              r_s1_valid, r_s1_sign;
    logic [EXP_W-1:0]  r_s1_aexp, r_s1_bexp;
    logic [FRAC_W-1:0] r_s1_afrac, r_s1_bfrac;
    logic [TAG_W-1:0]  r_s1_tag;
    logic              r_s1_anan, r_s1_ainf, r_s1_azero;
    logic              r_s1_bnan, r_s1_binf, r_s1_bzero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_aexp  <= '0;
            r_s1_bexp  <= '0;
            r_s1_afrac <= '0;
            r_s1_bfrac <= '0;
            r_s1_tag   <= '0;
            r_s1_anan  <= 1'b0;
            r_s1_ainf  <= 1'b0;
            r_s1_azero <= 1'b0;
            r_s1_bnan  <= 1'b0;
            r_s1_binf  <= 1'b0;
            r_s1_bzero <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_sign  <= a_sign ^ b_sign;
            r_s1_aexp  <= a_exp;
            r_s1_bexp  <= b_exp;
            r_s1_afrac <= a_frac;
            r_s1_bfrac <= b_frac;
            r_s1_tag   <= in_tag;
            r_s1_anan  <= w_a_nan;
            r_s1_ainf  <= w_a_inf;
            r_s1_azero <= w_a_zero;
            r_s1_bnan  <= w_b_nan;
            r_s1_binf  <= w_b_inf;
            r_s1_bzero <= w_b_zero;
        end
    end

    // ------------------------------------------------------------------
    // S2: mantissa product, exponent sum, special-case resolution
    // ------------------------------------------------------------------
    logic [c_PROD_W-1:0] w_ma, w_mb, w_prod;
    logic [c_SE_W-1:0]   w_esum;
    logic [1:0]          w_spc;

    assign w_ma   = {{(c_PROD_W-c_MANT_W){1'b0}}, 1'b1, r_s1_afrac};
    assign w_mb   = {{(c_PROD_W-c_MANT_W){1'b0}}, 1'b1, r_s1_bfrac};
    assign w_prod = w_ma * w_mb;
    assign w_esum = {2'b00, r_s1_aexp} + {2'b00, r_s1_bexp} - c_BIAS;

    always_comb begin
        w_spc = c_SPC_NONE;
        if (r_s1_anan | r_s1_bnan) begin
            w_spc = c_SPC_NAN;
        end else if ((r_s1_ainf & r_s1_bzero) | (r_s1_azero & r_s1_binf)) begin
            w_spc = c_SPC_NAN;
        end else if (r_s1_ainf | r_s1_binf) begin
            w_spc = c_SPC_INF;
        end else if (r_s1_azero | r_s1_bzero) begin
            w_spc = c_SPC_ZERO;
        end
    end

    logic                r_s2_valid, r_s2_sign;
    logic [c_PROD_W-1:0] r_s2_prod;
    logic [c_SE_W-1:0]   r_s2_exp;
    logic [1:0]          r_s2_spc;
    logic [TAG_W-1:0]    r_s2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_prod  <= '0;
            r_s2_exp   <= '0;
            r_s2_spc   <= c_SPC_NONE;
            r_s2_tag   <= '0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sign  <= r_s1_sign;
            r_s2_prod  <= w_prod;
            r_s2_exp   <= w_esum;
            r_s2_spc   <= w_spc;
            r_s2_tag   <= r_s1_tag;
        end
    end

    // ------------------------------------------------------------------
    // S3a: normalise and extract guard/round/sticky
    // ------------------------------------------------------------------
    // Product of two [1,2) mantissas lies in [1,4): at most one bit of shift.
    logic              w_msb;
    logic [FRAC_W-1:0] w_nfrac;
    logic              w_guard, w_round, w_sticky;
    logic [c_SE_W-1:0] w_nexp;

    assign w_msb    = r_s2_prod[c_PROD_W-1];
    assign w_nfrac  = w_msb ? r_s2_prod[c_PROD_W-2 -: FRAC_W] : r_s2_prod[c_PROD_W-3 -: FRAC_W];
    assign w_guard  = w_msb ? r_s2_prod[FRAC_W]   : r_s2_prod[FRAC_W-1];
    assign w_round  = w_msb ? r_s2_prod[FRAC_W-1] : r_s2_prod[FRAC_W-2];
    assign w_sticky = w_msb ? (|r_s2_prod[FRAC_W-2:0]) : (|r_s2_prod[FRAC_W-3:0]);
    assign w_nexp   = r_s2_exp + c_SE_W'(w_msb);

    logic              r_s3_valid, r_s3_sign;
    logic [FRAC_W-1:0] r_s3_frac;
    logic              r_s3_guard, r_s3_round, r_s3_sticky;
    logic [c_SE_W-1:0] r_s3_exp;
    logic [1:0]        r_s3_spc;
    logic [TAG_W-1:0]  r_s3_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_valid  <= 1'b0;
            r_s3_sign   <= 1'b0;
            r_s3_frac   <= '0;
            r_s3_guard  <= 1'b0;
            r_s3_round  <= 1'b0;
            r_s3_sticky <= 1'b0;
            r_s3_exp    <= '0;
            r_s3_spc    <= c_SPC_NONE;
            r_s3_tag    <= '0;
        end else if (w_adv) begin
            r_s3_valid  <= r_s2_valid;
            r_s3_sign   <= r_s2_sign;
            r_s3_frac   <= w_nfrac;
            r_s3_guard  <= w_guard;
            r_s3_round  <= w_round;
            r_s3_sticky <= w_sticky;
            r_s3_exp    <= w_nexp;
            r_s3_spc    <= r_s2_spc;
            r_s3_tag    <= r_s2_tag;
        end
    end

    // ------------------------------------------------------------------
    // S3b: round to nearest even, range check, pack into output register
    // ------------------------------------------------------------------
    logic              w_round_up, w_carry, w_lost, w_ovf, w_unf;
    logic [FRAC_W-1:0] w_frac_rnd;
    logic [c_SE_W-1:0] w_exp_f;

    assign w_round_up = r_s3_guard & (r_s3_round | r_s3_sticky | r_s3_frac[0]);
    // An all-ones fraction wraps to zero on increment, which is exactly the
    // packed fraction needed after a mantissa carry.
    assign w_frac_rnd = r_s3_frac + FRAC_W'(w_round_up);
    assign w_carry    = w_round_up & (&r_s3_frac);
    assign w_exp_f    = r_s3_exp + c_SE_W'(w_carry);
    assign w_lost     = r_s3_guard | r_s3_round | r_s3_sticky;
    assign w_ovf      = $signed(w_exp_f) >= $signed(c_EXP_MAX);
    assign w_unf      = w_exp_f[c_SE_W-1] | (w_exp_f == '0);

    logic [EXP_W-1:0]  w_res_exp;
    logic [FRAC_W-1:0] w_res_frac;
    logic              w_res_inv, w_res_ovf, w_res_unf, w_res_inx;

    always_comb begin
        w_res_exp  = '0;
        w_res_frac = '0;
        w_res_inv  = 1'b0;
        w_res_ovf  = 1'b0;
        w_res_unf  = 1'b0;
        w_res_inx  = 1'b0;
        case (r_s3_spc)
            c_SPC_NAN: begin
                w_res_exp  = '1;
                w_res_frac = c_QNAN_FRAC;
                w_res_inv  = 1'b1;
            end
            c_SPC_INF: begin
                w_res_exp = '1;
            end
            c_SPC_ZERO: begin
                w_res_exp = '0;
            end
            default: begin
                if (w_ovf) begin
                    w_res_exp = '1;
                    w_res_ovf = 1'b1;
                    w_res_inx = 1'b1;
                end else if (w_unf) begin
                    w_res_unf = 1'b1;
                    w_res_inx = 1'b1;
                end else begin
                    w_res_exp  = w_exp_f[EXP_W-1:0];
                    w_res_frac = w_frac_rnd;
                    w_res_inx  = w_lost;
                end
            end
        endcase
    end

    logic              r_out_valid, r_out_sign;
    logic [EXP_W-1:0]  r_out_exp;
    logic [FRAC_W-1:0] r_out_frac;
    logic [TAG_W-1:0]  r_out_tag;
    logic              r_out_inv, r_out_ovf, r_out_unf, r_out_inx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sign  <= 1'b0;
            r_out_exp   <= '0;
            r_out_frac  <= '0;
            r_out_tag   <= '0;
            r_out_inv   <= 1'b0;
            r_out_ovf   <= 1'b0;
            r_out_unf   <= 1'b0;
            r_out_inx   <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s3_valid;
            r_out_sign  <= r_s3_sign;
            r_out_exp   <= w_res_exp;
            r_out_frac  <= w_res_frac;
            r_out_tag   <= r_s3_tag;
            r_out_inv   <= w_res_inv;
            r_out_ovf   <= w_res_ovf;
            r_out_unf   <= w_res_unf;
            r_out_inx   <= w_res_inx;
        end
    end

    assign out_valid = r_out_valid;
    assign sign      = r_out_sign;
    assign exp       = r_out_exp;
    assign frac      = r_out_frac;
    assign out_tag   = r_out_tag;
    assign invalid   = r_out_inv;
    assign overflow  = r_out_ovf;
    assign underflow = r_out_unf;
    assign inexact   = r_out_inx;

endmodule
`default_nettype wire

// File: tb/tb_fmul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmul_pipe
// Purpose  : Self-checking bench for fmul_pipe (binary32 configuration).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmul_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic        a_sign, b_sign;
    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_frac, b_frac;
    logic [3:0]  in_tag, out_tag;
    logic        out_valid, out_ready;
    logic        sign;
    logic [7:0]  res_exp;
    logic [22:0] res_frac;
    logic        invalid, overflow, underflow, inexact;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard entry: {tag[3:0], invalid, overflow, underflow, inexact, word[31:0]}
    logic [39:0] sb[$];

    logic prev_stall = 1'b0;
    logic saw_block  = 1'b0;
    logic [40:0] prev_out = '0;
    logic rnd_done = 1'b0;

    logic [31:0] dir_a [8] = '{32'h3F800001, 32'h3F800001, 32'h7F800000, 32'hFF800000,
                               32'h7FC00001, 32'h80000000, 32'h7F000000, 32'h00800000};
    logic [31:0] dir_b [8] = '{32'h3FC00000, 32'h3F800001, 32'h00000000, 32'h3F800000,
                               32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F000000};
    logic [35:0] dir_x [8] = '{{4'b0001, 32'h3FC00002}, {4'b0001, 32'h3F800002},
                               {4'b1000, 32'h7FC00000}, {4'b0000, 32'hFF800000},
                               {4'b1000, 32'h7FC00000}, {4'b0000, 32'h80000000},
                               {4'b0101, 32'h7F800000}, {4'b0011, 32'h00000000}};

    fmul_pipe #(.EXP_W(8), .FRAC_W(23), .TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_sign    (a_sign),
        .a_exp     (a_exp),
        .a_frac    (a_frac),
        .b_sign    (b_sign),
        .b_exp     (b_exp),
        .b_frac    (b_frac),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .exp       (res_exp),
        .frac      (res_frac),
        .out_tag   (out_tag),
        .invalid   (invalid),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", name, obs, expv);
    endtask

    // Reference: exact integer product, then round the scaled value to 24 bits.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, sh;
        logic az, bz, ainf, binf, anan, bnan;
        longint p, q, rem, half;
        s    = a[31] ^ b[31];
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        az   = (ea == 0);
        bz   = (eb == 0);
        ainf = (ea == 255) && (a[22:0] == 0);
        binf = (eb == 255) && (b[22:0] == 0);
        anan = (ea == 255) && (a[22:0] != 0);
        bnan = (eb == 255) && (b[22:0] != 0);
        if (anan || bnan || (ainf && bz) || (az && binf)) return {4'b1000, s, 8'hFF, 23'h400000};
        if (ainf || binf) return {4'b0000, s, 8'hFF, 23'h0};
        if (az || bz) return {4'b0000, s, 31'h0};
        p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (64'sd1 <<< 47)) begin
            sh = 24;
            e++;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'sd1 <<< (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'sd1 <<< 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'h0};
        if (e <= 0) return {4'b0011, s, 31'h0};
        return {3'b000, (rem != 0), s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] f;
        int k;
        k = int'($urandom_range(0, 15));
        f = 23'($urandom);
        case (k)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 1) f = '0; end
            2:       e = 8'($urandom_range(1, 20));
            3:       e = 8'($urandom_range(230, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        if ($urandom_range(0, 2) == 0) f = {f[22:19], 19'b0};
        return {1'($urandom), e, f};
    endfunction

    // Present a beat; returns one tick after the edge that accepted it.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                        input logic [35:0] expv);
        {a_sign, a_exp, a_frac} = a;
        {b_sign, b_exp, b_frac} = b;
        in_tag   = t;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({t, expv});
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("send_timeout", 64'(in_ready), 64'(1));
    endtask

    task automatic drain(input string name);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check(name, 64'(sb.size()), 64'(0));
    endtask

    task automatic measure_latency(input string name);
        int lat;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        check(name, 64'(lat), 64'(3));
    endtask

    always @(negedge clk) begin : mon
        logic [39:0] ent;
        logic [40:0] cur;
        cur = {out_valid, sign, res_exp, res_frac, out_tag, invalid, overflow, underflow, inexact};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("stall_hold", 64'(cur), 64'(prev_out));
            if (out_valid && !in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'(0));
                end else begin
                    ent = sb.pop_front();
                    check("result", 64'({invalid, overflow, underflow, inexact, sign, res_exp, res_frac}),
                          64'(ent[35:0]));
                    check("tag", 64'(out_tag), 64'(ent[39:36]));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        {a_sign, a_exp, a_frac} = '0;
        {b_sign, b_exp, b_frac} = '0;
        in_tag    = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({out_valid, sign, res_exp, res_frac, out_tag,
                                     invalid, overflow, underflow, inexact}), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic multiply with latency measurement
        out_ready = 1'b1;
        send(32'h3FC00000, 32'h40000000, 4'h5, {4'b0000, 32'h40400000});
        in_valid = 1'b0;
        measure_latency("latency_basic");
        drain("drain_basic");

        // Directed rounding, special and range cases, back-to-back
        for (int i = 0; i < 8; i++) send(dir_a[i], dir_b[i], 4'(i + 6), dir_x[i]);
        drain("drain_directed");

        // Backpressure: out_ready low for cycles 4-7 while streaming
        saw_block = 1'b0;
        fork
            begin : bp_stream
                logic [31:0] ra, rb;
                for (int i = 0; i < 6; i++) begin
                    ra = {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
                    rb = {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
                    send(ra, rb, 4'(i), ref_mul(ra, rb));
                end
                in_valid = 1'b0;
            end
            begin : bp_ready
                out_ready = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");
        check("in_ready_dropped", 64'(saw_block), 64'(1));

        // Randomized traffic with random consumer stalls
        rnd_done = 1'b0;
        fork
            begin : rnd_stream
                logic [31:0] ra, rb;
                for (int i = 0; i < 40; i++) begin
                    ra = rnd_op();
                    rb = rnd_op();
                    send(ra, rb, 4'($urandom), ref_mul(ra, rb));
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin : rnd_ready
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain("drain_random");

        // Reset with three beats in flight, first one already at the output
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] ra, rb;
            ra = rnd_op();
            rb = rnd_op();
            send(ra, rb, 4'(10 + i), ref_mul(ra, rb));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("async_clear", 64'({out_valid, sign, res_exp, res_frac, out_tag,
                                   invalid, overflow, underflow, inexact}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        @(posedge clk);
        #1;
        check("no_stale_after_reset", 64'(seen), 64'(0));
        send(32'h40400000, 32'hC0000000, 4'hA, {4'b0000, 32'hC0C00000});
        in_valid = 1'b0;
        measure_latency("latency_after_reset");
        drain("drain_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
